// File: rtl/alu_result_capture.sv
// Captures one-hot ALU unit outputs as tagged words into a first-word-fall-through FIFO
// drained over valid/ready, with sticky overflow and flag-error indicators.
module alu_result_capture #(
    parameter int n      = 15,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              capture_en,
    input  logic [2*n:0]      Arith_OUT,
    input  logic              Carry_OUT,
    input  logic [n:0]        Logic_OUT,
    input  logic [1:0]        CMP_OUT,
    input  logic [n:0]        SHIFT_OUT,
    input  logic              Arith_Flag,
    input  logic              Logic_Flag,
    input  logic              CMP_Flag,
    input  logic              SHIFT_Flag,
    input  logic              clr_err,
    output logic [2*n+1:0]    out_data,
    output logic [1:0]        out_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              flag_err
);

    localparam int W = 2 * n + 2;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [3:0]        flags;
    logic              multi_flag;
    logic              one_flag;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              full;
    logic [W-1:0]      entry_data;
    logic [1:0]        entry_tag;
    logic [W+1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [W+1:0]      head;

    assign flags      = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    // Clearing the lowest set bit leaves something only if two or more flags are set.
    assign multi_flag = |(flags & (flags - 4'd1));
    assign one_flag   = (|flags) && !multi_flag;

    assign push_req  = capture_en && one_flag;
    assign full      = (fifo_count == FULL_COUNT);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        entry_data = '0;
        entry_tag  = 2'b00;
        if (Arith_Flag) begin
            entry_data = {Carry_OUT, Arith_OUT};
            entry_tag  = 2'b00;
        end else if (Logic_Flag) begin
            entry_data = {{(n + 1){1'b0}}, Logic_OUT};
            entry_tag  = 2'b01;
        end else if (CMP_Flag) begin
            entry_data = {{(2 * n){1'b0}}, CMP_OUT};
            entry_tag  = 2'b10;
        end else if (SHIFT_Flag) begin
            entry_data = {{(n + 1){1'b0}}, SHIFT_OUT};
            entry_tag  = 2'b11;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {entry_tag, entry_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Set conditions are checked before clr_err so a same-cycle set wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (capture_en && multi_flag) begin
                flag_err <= 1'b1;
            end else if (clr_err) begin
                flag_err <= 1'b0;
            end
        end
    end

    // Stale storage is masked so an empty FIFO reads as zero.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[W-1:0] : '0;
    assign out_tag  = out_valid ? head[W+1:W] : 2'b00;

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: directed captures push expected words,
// an independent monitor pops and compares on every accepted transfer.
module tb_alu_result_capture;

    logic        CLK = 1'b0;
    logic        RST;
    logic        capture_en;
    logic [30:0] Arith_OUT;
    logic        Carry_OUT;
    logic [15:0] Logic_OUT;
    logic [1:0]  CMP_OUT;
    logic [15:0] SHIFT_OUT;
    logic        Arith_Flag;
    logic        Logic_Flag;
    logic        CMP_Flag;
    logic        SHIFT_Flag;
    logic        clr_err;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        flag_err;

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    alu_result_capture #(.n(15), .DEPTH(4), .ADDR_W(2)) dut (
        .CLK(CLK), .RST(RST), .capture_en(capture_en),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .clr_err(clr_err), .out_data(out_data), .out_tag(out_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow), .flag_err(flag_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got %0h expected none", {out_tag, out_data});
            end else begin
                check_value("drain_word", {out_tag, out_data}, exp_q.pop_front());
            end
        end
    end

    task automatic apply_capture(input logic [3:0] flags, input logic [30:0] a, input logic c,
                                 input logic [15:0] l, input logic [1:0] cm, input logic [15:0] s,
                                 input logic [31:0] exp_data, input logic [1:0] exp_tag,
                                 input bit keep, input bit pop_too);
        @(posedge CLK); #1;
        Arith_OUT = a; Carry_OUT = c; Logic_OUT = l; CMP_OUT = cm; SHIFT_OUT = s;
        {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = flags;
        capture_en = 1'b1;
        if (pop_too) out_ready = 1'b1;
        if (keep) exp_q.push_back({exp_tag, exp_data});
        @(posedge CLK); #1;
        capture_en = 1'b0;
        {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = 4'b0000;
        if (pop_too) out_ready = 1'b0;
    endtask

    task automatic drain_all();
        int cycles;
        @(posedge CLK); #1;
        out_ready = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 50) begin
            @(posedge CLK);
            cycles++;
        end
        check_value("drain_done", 34'(exp_q.size()), 34'd0);
        @(posedge CLK); #1;
        out_ready = 1'b0;
        @(negedge CLK);
        check_value("drain_valid", 34'(out_valid), 34'd0);
        check_value("drain_count", 34'(fifo_count), 34'd0);
    endtask

    task automatic pulse_clr();
        @(posedge CLK); #1;
        clr_err = 1'b1;
        @(posedge CLK); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; capture_en = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
        Arith_OUT = '0; Carry_OUT = 1'b0; Logic_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
        {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = 4'b0000;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Idle after reset, consumer ready
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_value("idle_valid", 34'(out_valid), 34'd0);
            check_value("idle_count", 34'(fifo_count), 34'd0);
        end
        check_value("idle_overflow", 34'(overflow), 34'd0);
        check_value("idle_flag_err", 34'(flag_err), 34'd0);
        check_value("idle_data", 34'({out_tag, out_data}), 34'd0);
        @(posedge CLK); #1 out_ready = 1'b0;

        // Single arith word held until accepted
        apply_capture(4'b0001, 31'd300, 1'b0, 16'h0, 2'b00, 16'h0, 32'h0000012C, 2'b00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_value("hold_valid", 34'(out_valid), 34'd1);
            check_value("hold_word", {out_tag, out_data}, {2'b00, 32'h0000012C});
        end
        drain_all();

        // One word per unit, order preserved
        apply_capture(4'b0001, 31'h7FFFFFDD, 1'b1, 16'h0, 2'b00, 16'h0, 32'hFFFFFFDD, 2'b00, 1, 0);
        apply_capture(4'b0010, 31'h0, 1'b0, 16'h00AA, 2'b00, 16'h0, 32'h000000AA, 2'b01, 1, 0);
        apply_capture(4'b0100, 31'h0, 1'b0, 16'h0, 2'b10, 16'h0, 32'h00000002, 2'b10, 1, 0);
        apply_capture(4'b1000, 31'h0, 1'b0, 16'h0, 2'b00, 16'h00DE, 32'h000000DE, 2'b11, 1, 0);
        @(negedge CLK);
        check_value("units_count", 34'(fifo_count), 34'd4);
        drain_all();

        // Overflow: fifth word dropped; then push with pop while full
        for (int i = 1; i <= 5; i++) begin
            apply_capture(4'b0010, 31'h0, 1'b0, 16'(i), 2'b00, 16'h0, 32'(i), 2'b01, i <= 4, 0);
        end
        @(negedge CLK);
        check_value("ovf_count", 34'(fifo_count), 34'd4);
        check_value("ovf_sticky", 34'(overflow), 34'd1);
        apply_capture(4'b1000, 31'h0, 1'b0, 16'h0, 2'b00, 16'h0006, 32'h00000006, 2'b11, 1, 1);
        @(negedge CLK);
        check_value("fullpop_count", 34'(fifo_count), 34'd4);
        check_value("fullpop_overflow", 34'(overflow), 34'd1);
        drain_all();
        pulse_clr();
        @(negedge CLK);
        check_value("ovf_cleared", 34'(overflow), 34'd0);

        // Flag errors, NOP capture, clear, and set-beats-clear
        apply_capture(4'b0110, 31'h0, 1'b0, 16'h1234, 2'b01, 16'h0, 32'h0, 2'b00, 0, 0);
        @(negedge CLK);
        check_value("multi_flag_err", 34'(flag_err), 34'd1);
        check_value("multi_count", 34'(fifo_count), 34'd0);
        apply_capture(4'b0000, 31'h5, 1'b0, 16'h5, 2'b01, 16'h5, 32'h0, 2'b00, 0, 0);
        @(negedge CLK);
        check_value("nop_flag_err", 34'(flag_err), 34'd1);
        check_value("nop_count", 34'(fifo_count), 34'd0);
        pulse_clr();
        @(negedge CLK);
        check_value("clr_flag_err", 34'(flag_err), 34'd0);
        @(posedge CLK); #1;
        clr_err = 1'b1;
        apply_capture(4'b1001, 31'h0, 1'b0, 16'h0, 2'b00, 16'h0, 32'h0, 2'b00, 0, 0);
        clr_err = 1'b0;
        @(negedge CLK);
        check_value("set_wins", 34'(flag_err), 34'd1);

        // Reset mid-stream with a capture pending
        for (int i = 0; i < 3; i++) begin
            apply_capture(4'b0100, 31'h0, 1'b0, 16'h0, 2'(i + 1), 16'h0, 32'(i + 1), 2'b10, 1, 0);
        end
        @(negedge CLK);
        check_value("pre_rst_count", 34'(fifo_count), 34'd3);
        @(posedge CLK); #1;
        RST = 1'b1; capture_en = 1'b1; Arith_Flag = 1'b1; Arith_OUT = 31'h55;
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0; capture_en = 1'b0; Arith_Flag = 1'b0;
        @(negedge CLK);
        check_value("rst_count", 34'(fifo_count), 34'd0);
        check_value("rst_valid", 34'(out_valid), 34'd0);
        check_value("rst_word", {out_tag, out_data}, 34'd0);
        check_value("rst_flag_err", 34'(flag_err), 34'd0);
        check_value("rst_overflow", 34'(overflow), 34'd0);
        apply_capture(4'b1000, 31'h0, 1'b0, 16'h0, 2'b00, 16'hBEEF, 32'h0000BEEF, 2'b11, 1, 0);
        drain_all();

        check_value("queue_empty", 34'(exp_q.size()), 34'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Downstream consumer of the ALU top block.
- Each cycle `capture_en` is high, samples the ALU unit outputs and the four one-hot unit flags.
- Selects the active unit's result, formats it into one tagged word, and buffers it in a first-word-fall-through FIFO.
- Drains over a valid/ready handshake toward the register file / UART formatter.
- Keeps sticky overflow and flag-error indicators.

Parameters:
- n, 15: ALU operand MSB index; operands are n+1 bits, Arith_OUT is 2n+1 bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 2: log2(DEPTH); pointer width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- capture_en  in  1  sample ALU outputs this cycle.
- Arith_OUT  in  2n+1  arithmetic result, signed.
- Carry_OUT  in  1  carry/borrow from arithmetic unit.
- Logic_OUT  in  n+1  logic unit result.
- CMP_OUT  in  2  compare unit result.
- SHIFT_OUT  in  n+1  shift unit result.
- Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  unit-active flags.
- clr_err  in  1  clears sticky error bits.
- out_data  out  2n+2  head-of-FIFO result word.
- out_tag  out  2  source of out_data: 00 arith, 01 logic, 10 cmp, 11 shift.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head this cycle.
- fifo_count  out  ADDR_W+1  occupied entries, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full and no pop.
- flag_err  out  1  sticky: capture with more than one flag set.

Behaviour:
- Reset (RST high at a clock edge, taking priority over all other inputs):
  - Pointers and fifo_count go to 0; overflow and flag_err go to 0.
  - out_valid is 0; out_data and out_tag read 0.
  - Reset mid-stream discards all buffered entries.
- Word formatting, combinational from the inputs:
  - Arith: out_data = {Carry_OUT, Arith_OUT}, raw bits, no sign extension beyond 2n+2.
  - Logic: {(n+1)'b0, Logic_OUT}.
  - CMP: {2n'b0, CMP_OUT}.
  - Shift: {(n+1)'b0, SHIFT_OUT}.
- Push request: capture_en high and exactly one flag high.
  - capture_en with zero flags: no push, no error (ALU NOP).
  - capture_en with two or more flags: no push, flag_err set to 1.
- Pop: out_valid && out_ready.
  - Pop when empty cannot occur, since out_valid is 0.
  - out_ready while empty is ignored.
- Push and pop in the same cycle:
  - Not full, not empty: both occur; count unchanged.
  - Full: pop frees the slot and the push is accepted; count stays DEPTH; no overflow.
  - Empty: push only. The new word appears on out_data in the next cycle, giving 1-cycle latency from capture to out_valid.
- Push while full without pop: word dropped, overflow set to 1, FIFO contents unchanged.
- Pointers wrap modulo DEPTH. fifo_count is the exact occupancy.
- out_valid = (fifo_count != 0).
- out_data/out_tag always show the head entry; stable while out_valid && !out_ready.
- Sticky bits:
  - Cleared by clr_err at the next edge.
  - If a set condition and clr_err occur in the same cycle, set wins.
- No combinational path from out_ready to out_valid/out_data.

Test Plan:
1. Reset then idle, out_ready=1 -> out_valid=0, fifo_count=0, overflow=0, flag_err=0 for 10 cycles.
2. Arith_Flag=1, Arith_OUT=300, Carry_OUT=0, capture_en pulse, out_ready=0 -> next cycle out_valid=1, out_data=0x0000012C, out_tag=00; held stable until out_ready=1, then out_valid=0.
3. Arith_OUT=-35 (31'h7FFFFFDD), Carry_OUT=1 -> out_data=0xFFFFFFDD, tag 00. Logic_OUT=16'h00AA -> 0x000000AA, tag 01. CMP_OUT=2'b10 -> 0x00000002, tag 10. SHIFT_OUT=16'h00DE -> 0x000000DE, tag 11. Order preserved on drain.
4. out_ready=0, five consecutive captures with DEPTH=4 -> fifo_count=4, overflow=1, 5th word absent on drain. Then a capture with simultaneous pop while full -> accepted, count stays 4, overflow unchanged.
5. capture_en with Logic_Flag=CMP_Flag=1 -> no push, flag_err=1. capture_en with all flags 0 -> no push, flag_err unchanged. clr_err -> flag_err=0 next cycle.
6. Three entries buffered, RST asserted for one cycle with capture_en=1 -> fifo_count=0, out_valid=0, sticky bits 0, no entry from that cycle retained.
